// File: rtl/cla_pkg.sv
// Shared types and constants for the cacheline adaptor (256-bit line <-> 4x64-bit bursts).
package cla_pkg;

  localparam int unsigned LineW  = 256;
  localparam int unsigned BurstW = 64;
  localparam int unsigned AddrW  = 32;

  localparam int unsigned BEATS = LineW / BurstW;
  localparam int unsigned OFFS  = $clog2(LineW / 8);
  localparam int unsigned CntW  = $clog2(BEATS);

  typedef logic [LineW-1:0]  line_t;
  typedef logic [BurstW-1:0] burst_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cla_state_t;

  function automatic logic [AddrW-1:0] line_align(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:OFFS], {OFFS{1'b0}}};
  endfunction

endpackage

// File: rtl/cla_beat_buf.sv
// Line-wide buffer with parallel load, per-beat write enable and beat select.
module cla_beat_buf
  import cla_pkg::*;
#(
  parameter int unsigned LineW  = cla_pkg::LineW,
  parameter int unsigned BurstW = cla_pkg::BurstW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [LineW-1:0]  line_i,
  input  logic              beat_we_i,
  input  logic [CntW-1:0]   beat_idx_i,
  input  logic [BurstW-1:0] beat_i,
  output logic [LineW-1:0]  line_o,
  output logic [BurstW-1:0] beat_o
);

  logic [LineW-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (beat_we_i) begin
      line_d[BurstW*beat_idx_i +: BurstW] = beat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[BurstW*beat_idx_i +: BurstW];

endmodule

// File: rtl/cacheline_adaptor.sv
// Converts cache line fills/writebacks into 4-beat memory bursts.
// Define CLA_PERF_EN to add saturating rd_count/wr_count completion counters.
module cacheline_adaptor
  import cla_pkg::*;
#(
  parameter int unsigned LINE_W  = cla_pkg::LineW,
  parameter int unsigned BURST_W = cla_pkg::BurstW,
  parameter int unsigned ADDR_W  = cla_pkg::AddrW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CLA_PERF_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);

  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  cla_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;
  logic               fill_we, wb_load;
  logic [BURST_W-1:0] wb_beat;
  logic [LINE_W-1:0]  wb_line_unused;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;
    fill_we = 1'b0;
    wb_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Writeback wins over a simultaneous fill; the cache re-presents the read.
        if (write_i) begin
          addr_d  = line_align(address_i);
          cnt_d   = '0;
          write_d = 1'b1;
          wb_load = 1'b1;
          state_d = WR;
        end else if (read_i) begin
          addr_d  = line_align(address_i);
          cnt_d   = '0;
          read_d  = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        if (resp_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  // Separate fill and writeback buffers keep line_o untouched by writebacks.
  cla_beat_buf #(
    .LineW  (LINE_W),
    .BurstW (BURST_W)
  ) u_fill_buf (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (1'b0),
    .line_i     ('0),
    .beat_we_i  (fill_we),
    .beat_idx_i (cnt_q),
    .beat_i     (burst_i),
    .line_o     (line_o),
    .beat_o     ()
  );

  cla_beat_buf #(
    .LineW  (LINE_W),
    .BurstW (BURST_W)
  ) u_wb_buf (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (wb_load),
    .line_i     (line_i),
    .beat_we_i  (1'b0),
    .beat_idx_i (cnt_q),
    .beat_i     ('0),
    .line_o     (wb_line_unused),
    .beat_o     (wb_beat)
  );

  assign burst_o   = (state_q == WR) ? wb_beat : '0;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

`ifdef CLA_PERF_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == RD && state_d == DONE && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
    if (state_q == WR && state_d == DONE && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: fills, writebacks, gaps, priority and reset.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef CLA_PERF_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [31:0]  exp_addr_q[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef CLA_PERF_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_addr(input string name);
    logic [31:0] exp;
    checks++;
    if (exp_addr_q.size() == 0) begin
      errors++;
      $display("FAIL %s address scoreboard empty, got %h", name, address_o);
    end else begin
      exp = exp_addr_q.pop_front();
      if (address_o !== exp) begin
        errors++;
        $display("FAIL %s address_o got %h want %h", name, address_o, exp);
      end
    end
  endtask

  // Fill: pat bit k is resp_i in the k-th RD cycle; beyond plen resp_i stays high.
  task automatic run_read(input string name, input logic [31:0] addr, input logic [255:0] data,
                          input logic [15:0] pat, input int plen);
    int beat = 0;
    int cyc = 0;
    logic r;
    logic [255:0] exp;
    read_i    = 1'b1;
    address_i = addr;
    exp_addr_q.push_back({addr[31:5], 5'b0});
    exp_line_q.push_back(data);
    step();
    check_addr(name);
    checks++;
    if (read_o !== 1'b1 || write_o !== 1'b0) begin
      errors++;
      $display("FAIL %s start read_o/write_o got %b/%b want 1/0", name, read_o, write_o);
    end
    while (beat < 4 && cyc < 64) begin
      r = (cyc < plen) ? pat[cyc] : 1'b1;
      resp_i  = r;
      burst_i = r ? data[64*beat +: 64] : {$urandom, $urandom};
      checks++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        errors++;
        $display("FAIL %s beat %0d read_o/resp_o got %b/%b want 1/0", name, beat, read_o, resp_o);
      end
      step();
      if (r) beat++;
      cyc++;
    end
    resp_i = 1'b0;
    checks++;
    if (beat != 4) begin
      errors++;
      $display("FAIL %s timeout beats got %0d want 4", name, beat);
    end
    checks++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done resp_o/read_o got %b/%b want 1/0", name, resp_o, read_o);
    end
    exp = exp_line_q.pop_front();
    checks++;
    if (line_o !== exp) begin
      errors++;
      $display("FAIL %s line_o got %h want %h", name, line_o, exp);
    end
    read_i = 1'b0;
    step();
    checks++;
    if (resp_o !== 1'b0 || line_o !== exp) begin
      errors++;
      $display("FAIL %s after done resp_o=%b line_o=%h want 0 and %h", name, resp_o, line_o, exp);
    end
  endtask

  task automatic run_write(input string name, input logic [31:0] addr, input logic [255:0] data,
                           input logic [15:0] pat, input int plen, input logic also_read);
    int beat = 0;
    int cyc = 0;
    logic r;
    logic [63:0] exp;
    write_i   = 1'b1;
    read_i    = also_read;
    line_i    = data;
    address_i = addr;
    exp_addr_q.push_back({addr[31:5], 5'b0});
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(data[64*i +: 64]);
    step();
    line_i = {8{$urandom}};
    check_addr(name);
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0) begin
      errors++;
      $display("FAIL %s start write_o/read_o got %b/%b want 1/0", name, write_o, read_o);
    end
    while (beat < 4 && cyc < 64) begin
      r = (cyc < plen) ? pat[cyc] : 1'b1;
      resp_i = r;
      checks++;
      if (write_o !== 1'b1 || resp_o !== 1'b0) begin
        errors++;
        $display("FAIL %s beat %0d write_o/resp_o got %b/%b want 1/0", name, beat, write_o,
                 resp_o);
      end
      if (r) begin
        exp = exp_beat_q.pop_front();
        checks++;
        if (burst_o !== exp) begin
          errors++;
          $display("FAIL %s burst_o beat %0d got %h want %h", name, beat, burst_o, exp);
        end
        beat++;
      end
      step();
      cyc++;
    end
    resp_i = 1'b0;
    checks++;
    if (beat != 4) begin
      errors++;
      $display("FAIL %s timeout beats got %0d want 4", name, beat);
    end
    checks++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      errors++;
      $display("FAIL %s done resp_o/write_o got %b/%b want 1/0", name, resp_o, write_o);
    end
    write_i = 1'b0;
    read_i  = 1'b0;
    step();
    checks++;
    if (resp_o !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_o second cycle got %b want 0", name, resp_o);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0 || read_o !== 1'b0 ||
        write_o !== 1'b0 || resp_o !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs line=%h burst=%h addr=%h rd=%b wr=%b resp=%b want all 0", name,
               line_o, burst_o, address_o, read_o, write_o, resp_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #2;
    check_all_zero("reset");
    step();
    rst = 1'b1;
    step();
    // Stray acknowledges while idle must be ignored.
    resp_i = 1'b1;
    step();
    step();
    resp_i = 1'b0;
    check_all_zero("idle_resp_ignored");
  endtask

  task automatic test_read_b2b();
    run_read("read_b2b", 32'h0000_1234,
             {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'h0, 0);
  endtask

  task automatic test_write();
    run_write("write", 32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 16'h0, 0, 1'b0);
  endtask

  task automatic test_gapped();
    run_read("gapped_read", 32'h8000_07FF, {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom}, 16'h0059, 7);
    run_write("gapped_write", 32'h0000_0123, {8{$urandom}}, 16'h0059, 7, 1'b0);
  endtask

  task automatic test_simultaneous();
    run_write("rw_priority", 32'h0000_2000, {8{$urandom}}, 16'h0, 0, 1'b1);
    run_read("rw_refill", 32'h0000_2000, {8{$urandom}}, 16'h0, 0);
  endtask

  task automatic test_reset_mid_burst();
    read_i = 1'b1;
    address_i = 32'h0000_3000;
    step();
    resp_i = 1'b1;
    burst_i = 64'hDEAD_BEEF_0000_0001;
    step();
    burst_i = 64'hDEAD_BEEF_0000_0002;
    step();
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_burst");
    resp_i = 1'b0;
    read_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    run_read("post_reset_read", 32'h0000_3040, {8{$urandom}}, 16'h0005, 4);
  endtask

`ifdef CLA_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) run_read("perf_rd", 32'h100 * i, {8{$urandom}}, 16'h0, 0);
    for (int i = 0; i < 2; i++) run_write("perf_wr", 32'h40 * i, {8{$urandom}}, 16'h0, 0, 1'b0);
    checks++;
    if (rd_count !== 32'd3 || wr_count !== 32'd2) begin
      errors++;
      $display("FAIL perf_counts rd=%0d wr=%0d want 3 and 2", rd_count, wr_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_b2b();
    test_write();
    test_gapped();
    test_simultaneous();
    test_reset_mid_burst();
`ifdef CLA_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
